// File: rtl/xgriscv_wb_queue_pkg.sv
// ---------------------------------------------------------------------------
// xgriscv_wb_queue_pkg
//   Shared types and widths for the write-back queue.
//
//   Core-wide width macros normally come from xgriscv_defines.v:
//     RFIDX_WIDTH, XLEN, ADDR_SIZE, RFREG_NUM, WBQ_DEPTH_DEFAULT
//   Each macro is given a fallback value here only when it is not already
//   defined, so a core build that pulls in xgriscv_defines.v first keeps
//   its own values.
//
//   Optional feature macro: WBQ_FWD_EN (decode-stage forwarding, see top).
// ---------------------------------------------------------------------------
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif
`ifndef WBQ_DEPTH_DEFAULT
`define WBQ_DEPTH_DEFAULT 4
`endif

package xgriscv_wb_queue_pkg;

  localparam int RFIDX_W = `RFIDX_WIDTH;
  localparam int XLEN_W  = `XLEN;
  localparam int ADDR_W  = `ADDR_SIZE;
  localparam int RF_NUM  = `RFREG_NUM;

  // One queued register-file write.
  typedef struct packed {
    logic [RFIDX_W-1:0] rd;
    logic [XLEN_W-1:0]  data;
    logic [ADDR_W-1:0]  pc;
  } wbq_entry_t;

endpackage

// File: rtl/xgriscv_wbq_fwd.sv
// ---------------------------------------------------------------------------
// xgriscv_wbq_fwd
//   Combinational youngest-match search over the write-back queue entries.
//   Walks the live window from head (oldest) to head+count-1 (youngest);
//   a later match overrides an earlier one, so the youngest write wins.
//
//   Ports:
//     ent_rd / ent_data  in   per-slot destination register and data
//     head               in   index of the oldest live entry
//     count              in   number of live entries
//     rs                 in   decode read address (x0 never hits)
//     hit                out  a live entry targets rs
//     data               out  youngest matching data, 0 when no hit
// ---------------------------------------------------------------------------
module xgriscv_wbq_fwd
  import xgriscv_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic [RFIDX_W-1:0] ent_rd   [DEPTH],
  input  logic [XLEN_W-1:0]  ent_data [DEPTH],
  input  logic [PW-1:0]      head,
  input  logic [CW-1:0]      count,
  input  logic [RFIDX_W-1:0] rs,
  output logic               hit,
  output logic [XLEN_W-1:0]  data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (ent_rd[idx] == rs) && (rs != '0)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/xgriscv_wb_queue.sv
// ---------------------------------------------------------------------------
// xgriscv_wb_queue
//   In-order write-back queue feeding the register file write port. Two
//   producers: port A (in-order pipeline) and port B (long-latency unit).
//   One entry drains per cycle while the queue is non-empty.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     a_valid/a_ready/a_rd/a_data/a_pc   port A request
//     b_valid/b_ready/b_rd/b_data/b_pc   port B request
//     write, writeaddress, writedata, pc register-file write (head entry)
//     empty                      queue holds no entries
//     rs1, rs2                   decode read addresses
//     fwd1_hit/fwd1_data, fwd2_hit/fwd2_data  forwarding results
//
//   Macro WBQ_FWD_EN: when defined, forwarding search logic is built;
//   otherwise the fwd outputs are tied to 0 and decode stalls on !empty.
// ---------------------------------------------------------------------------
module xgriscv_wb_queue
  import xgriscv_wb_queue_pkg::*;
#(
  parameter int DEPTH = `WBQ_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [RFIDX_W-1:0] a_rd,
  input  logic [XLEN_W-1:0]  a_data,
  input  logic [ADDR_W-1:0]  a_pc,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [RFIDX_W-1:0] b_rd,
  input  logic [XLEN_W-1:0]  b_data,
  input  logic [ADDR_W-1:0]  b_pc,
  output logic               write,
  output logic [RFIDX_W-1:0] writeaddress,
  output logic [XLEN_W-1:0]  writedata,
  output logic [ADDR_W-1:0]  pc,
  output logic               empty,
  input  logic [RFIDX_W-1:0] rs1,
  input  logic [RFIDX_W-1:0] rs2,
  output logic               fwd1_hit,
  output logic [XLEN_W-1:0]  fwd1_data,
  output logic               fwd2_hit,
  output logic [XLEN_W-1:0]  fwd2_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] a_slot;
  logic [CW-1:0] count_q, count_d;

  logic a_enq, b_enq, deq;
  logic [DEPTH-1:0] a_we, b_we;

  wbq_entry_t entry_q [DEPTH];
  wbq_entry_t a_entry, b_entry;

  // Registered copy of the head slot so the write outputs come straight
  // from flops, reset to 0, and hold their last value while empty.
  wbq_entry_t head_out_q, head_out_d;

  assign a_entry = '{rd: a_rd, data: a_data, pc: a_pc};
  assign b_entry = '{rd: b_rd, data: b_data, pc: b_pc};

  // Readiness looks only at registered count: a pop in the same cycle does
  // not free a slot. A needs two free slots when B may take one of them.
  always_comb begin
    b_ready = (count_q < CW'(DEPTH));
    a_ready = (count_q <= CW'(DEPTH - 2)) ||
              ((count_q == CW'(DEPTH - 1)) && !b_valid);
    // x0 writes are handshaken but never stored.
    b_enq   = b_valid && b_ready && (b_rd != '0);
    a_enq   = a_valid && a_ready && (a_rd != '0);
    deq     = (count_q != '0);
    // B issued earlier, so it takes the older slot.
    a_slot  = tail_q + PW'(b_enq);
    tail_d  = tail_q + PW'(a_enq) + PW'(b_enq);
    head_d  = head_q + PW'(deq);
    count_d = count_q + CW'(a_enq) + CW'(b_enq) - CW'(deq);
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign b_we[gi] = b_enq && (tail_q == PW'(gi));
    assign a_we[gi] = a_enq && (a_slot == PW'(gi));
  end

  // Next head view: the slot at head_d, bypassing a write landing there
  // in this same cycle (needed when the queue was empty or nearly so).
  always_comb begin
    head_out_d = head_out_q;
    if (count_d != '0) begin
      head_out_d = entry_q[head_d];
      if (b_we[head_d]) head_out_d = b_entry;
      if (a_we[head_d]) head_out_d = a_entry;
    end
  end

  // Entry storage is not reset; only live entries are ever observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (b_we[i]) entry_q[i] <= b_entry;
      if (a_we[i]) entry_q[i] <= a_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      head_out_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      head_out_q <= head_out_d;
    end
  end

  assign write        = (count_q != '0);
  assign empty        = (count_q == '0);
  assign writeaddress = head_out_q.rd;
  assign writedata    = head_out_q.data;
  assign pc           = head_out_q.pc;

`ifdef WBQ_FWD_EN
  logic [RFIDX_W-1:0] ent_rd   [DEPTH];
  logic [XLEN_W-1:0]  ent_data [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd_view
    assign ent_rd[gi]   = entry_q[gi].rd;
    assign ent_data[gi] = entry_q[gi].data;
  end

  xgriscv_wbq_fwd #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fwd1 (
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .head     (head_q),
    .count    (count_q),
    .rs       (rs1),
    .hit      (fwd1_hit),
    .data     (fwd1_data)
  );

  xgriscv_wbq_fwd #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fwd2 (
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .head     (head_q),
    .count    (count_q),
    .rs       (rs2),
    .hit      (fwd2_hit),
    .data     (fwd2_data)
  );
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: doc/xgriscv_wb_queue.md
# xgriscv_wb_queue

Write-back queue that is the writer side of the core's register file write port. It accepts register-write requests from two producers: the in-order pipeline (port A) and the long-latency load/mul-div unit (port B). It holds them in a small in-order FIFO and drives exactly one write per cycle into the register file's `write`/`writeaddress`/`writedata`/`pc` inputs. Optionally, it forwards not-yet-committed data to the decode-stage read addresses.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; power of two, ≥ 2.

Ports (widths use the macros in `xgriscv_defines.v`):
- `clk`  in  1  core clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  port A write request.
- `a_ready`  out  1  port A accepted this cycle if `a_valid`.
- `a_rd`  in  `RFIDX_WIDTH`  destination register.
- `a_data`  in  `XLEN`  write data.
- `a_pc`  in  `ADDR_SIZE`  pc of producing instruction.
- `b_valid`, `b_ready`, `b_rd`, `b_data`, `b_pc`: same as port A, for port B.
- `write`  out  1  register-file write enable.
- `writeaddress`  out  `RFIDX_WIDTH`  head entry rd.
- `writedata`  out  `XLEN`  head entry data.
- `pc`  out  `ADDR_SIZE`  head entry pc, for the commit trace.
- `empty`  out  1  queue holds no entries.
- `rs1`, `rs2`  in  `RFIDX_WIDTH`  decode read addresses.
- `fwd1_hit`, `fwd2_hit`  out  1  queued value exists for `rs1`/`rs2`.
- `fwd1_data`, `fwd2_data`  out  `XLEN`  forwarded value.

## Operation
- The FIFO has a head pointer, a tail pointer (each log2(DEPTH) bits, wrapping modulo DEPTH) and a `count` (0..DEPTH).
- Readiness is computed from the registered `count` only; a same-cycle dequeue does not free a slot:
  - `b_ready` = `count < DEPTH`.
  - `a_ready` = `count <= DEPTH-2`, or (`count == DEPTH-1` and `!b_valid`).
- Enqueue when `x_valid && x_ready`. If A and B both enqueue in the same cycle, B takes the older slot at `tail` and A takes `tail+1`, because B's instruction issued earlier.
- Requests with rd == 0 are accepted (ready obeys the rules above) but not stored, and count does not change.
- Drain: `write` = (`count != 0`). The other write outputs show the head entry. Head advances at every posedge where `count != 0`; the register file commits on the intervening negedge.
- Count update: count_next = count + enqueues − (count != 0). Simultaneous enqueue and dequeue is legal at any fill level that readiness allows.
- Forwarding (see Configuration): `fwdN_hit` = some valid queued entry has rd == `rsN` and `rsN != 0`. `fwdN_data` is the data of the youngest such entry; otherwise 0. Requests arriving in the current cycle are not searched.

## Timing
- Reset values: count = 0, head = tail = 0, `write` = 0, `writeaddress` = 0, `writedata` = 0, `pc` = 0, `empty` = 1, `a_ready` = `b_ready` = 1 (after reset releases), `fwd*_hit` = 0. Entry storage is not reset.
- Latency: a request accepted at posedge N into an empty queue drives `write` = 1 from just after posedge N. It commits at the following negedge and is popped at posedge N+1. Minimum latency is 1 cycle.
- Throughput is one commit per cycle. Up to two enqueues per cycle.
- Full (count == DEPTH): both ready signals are 0.
- Empty: `write` = 0 and outputs hold the last head-slot contents; consumers use `write` only.
- Reset asserted mid-operation discards all entries in that cycle; no write is presented in the next cycle.
- Ready and forwarding outputs are combinational from registered state plus `b_valid`/`rsN`. There is no path from `x_ready` back to `x_valid`.

## Configuration
- `WBQ_FWD_EN` defined: forwarding comparators and youngest-match priority logic are built.
- `WBQ_FWD_EN` undefined: `fwd1_hit` = `fwd2_hit` = 0 and `fwd1_data` = `fwd2_data` = 0 constantly. The decode stage must stall on `!empty` instead.

## Structure
- `RFIDX_WIDTH`, `XLEN`, `ADDR_SIZE` and `RFREG_NUM` come from `xgriscv_defines.v`.
- Add `WBQ_DEPTH_DEFAULT` to `xgriscv_defines.v`.
- One sub-module, `xgriscv_wbq_fwd`: a combinational youngest-match search over the entry array, taking head, count and one rs. It is instantiated twice and only exists under `WBQ_FWD_EN`.

## Test plan
- **Single write.** Reset, then A: rd=5, data=0x1234, pc=0x100 for one cycle. Required: next cycle `write`=1, `writeaddress`=5, `writedata`=0x1234, `pc`=0x100. One cycle later `write`=0 and `empty`=1.
- **Same-cycle ordering.** A (rd=3, 0xA) and B (rd=3, 0xB) in one cycle with an empty queue. Required: commits are 0xB then 0xA on consecutive cycles. With `WBQ_FWD_EN`, `rs1`=3 gives hit and 0xA while both are queued.
- **x0 drop.** A with rd=0, data=0xFFFF. Required: `a_ready`=1, count stays 0, `write` never asserts.
- **Full and near-full.** DEPTH=4, hold the queue full. Required: `a_ready`=`b_ready`=0. At count=3 with both valid: `b_ready`=1 and `a_ready`=0. At count=3 with only A valid: `a_ready`=1.
- **Wrap-around.** 10 back-to-back B writes rd=1..10 with data=rd. Required: 10 commits in order with no loss; pointers wrap cleanly.
- **Reset mid-operation.** Fill 3 entries, assert reset for one cycle. Required: `write`=0 and `empty`=1 on the next cycle, and no stale commits after release.
